// File: rtl/div_seq_if.sv
// Operand/result bundle between the execute stage and the multi-cycle divider.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             div_startE;
  logic             div_signedE;
  logic [WIDTH-1:0] opaE;
  logic [WIDTH-1:0] opbE;
  logic             annul;
  logic             stall_div;
  logic             div_ready;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output div_startE, div_signedE, opaE, opbE, annul,
    input  stall_div, div_ready, hi_o, lo_o
  );

  modport slave (
    input  div_startE, div_signedE, opaE, opbE, annul,
    output stall_div, div_ready, hi_o, lo_o
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU in E: one quotient bit per cycle,
// stalls the pipeline while busy, quotient to lo_o and remainder to hi_o.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      resetn,
  div_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             stall_s;
  logic             ready_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] rem_nx_s;
  logic [WIDTH-1:0] quo_nx_s;

  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
    return (~v) + W_ONE;
  endfunction

  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v, input logic sg);
    return (sg && v[WIDTH-1]) ? neg_f(v) : v;
  endfunction

  // One restoring step: a non-negative trial (MSB clear) keeps the subtraction.
  always_comb begin
    rem_sh_s = {rem_q, quo_q[WIDTH-1]};
    trial_s  = rem_sh_s - {1'b0, dvs_q};
    rem_nx_s = trial_s[WIDTH] ? rem_sh_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
    quo_nx_s = {quo_q[WIDTH-2:0], ~trial_s[WIDTH]};
  end

  // Next-state and outputs; annul forces IDLE and drops stall/ready at once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stall_s = 1'b0;
    ready_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.div_startE && !bus.annul) begin
          stall_s = 1'b1;
          qsign_d = bus.div_signedE & (bus.opaE[WIDTH-1] ^ bus.opbE[WIDTH-1]);
          rsign_d = bus.div_signedE & bus.opaE[WIDTH-1];
          dvs_d   = abs_f(bus.opbE, bus.div_signedE);
          quo_d   = abs_f(bus.opaE, bus.div_signedE);
          rem_d   = '0;
          cnt_d   = '0;
          if (bus.opbE == '0) begin
            hi_d    = bus.opaE;
            lo_d    = '1;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus.annul) begin
          state_d = IDLE;
        end else begin
          stall_s = 1'b1;
          rem_d   = rem_nx_s;
          quo_d   = quo_nx_s;
          cnt_d   = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            lo_d    = qsign_q ? neg_f(quo_nx_s) : quo_nx_s;
            hi_d    = rsign_q ? neg_f(rem_nx_s) : rem_nx_s;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      DONE: begin
        ready_s = ~bus.annul;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.stall_div = stall_s;
  assign bus.div_ready = ready_s;
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;
endmodule
